// File: rtl/uart_pkg.sv
// Shared types and constants for the UART boot loader: FSM state encoding and
// header/word byte counts.
package uart_pkg;

    typedef enum logic [2:0] {
        Idle,
        RecvLen,
        RecvData,
        RecvChk,
        Done,
        Error
    } boot_state_e;

    localparam int unsigned BootLenBytes = 4;
    localparam int unsigned WordBytes    = 4;

    function automatic logic is_busy(input boot_state_e s);
        return (s == RecvLen) || (s == RecvData) || (s == RecvChk);
    endfunction

endpackage

// File: rtl/uart_word_packer.sv
// Little-endian byte-to-word packer: places each valid byte in the next lane
// and flags the byte that completes a word. Used for the header and the payload.
module uart_word_packer
    import uart_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        clear_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_complete_o
);

    localparam int unsigned LaneW = $clog2(WordBytes);

    logic [LaneW-1:0] byte_cnt_q, byte_cnt_d;
    logic [31:0]      word_q, word_d;

    // word_o already carries the incoming byte so the consumer can act on the
    // completing byte in the same cycle it arrives.
    always_comb begin
        word_o                            = word_q;
        word_o[{byte_cnt_q, 3'b000} +: 8] = byte_i;
        word_complete_o = byte_vld_i && (byte_cnt_q == LaneW'(WordBytes - 1));
        byte_cnt_d      = byte_cnt_q;
        word_d          = word_q;
        if (clear_i) begin
            byte_cnt_d = '0;
            word_d     = '0;
        end else if (byte_vld_i) begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            word_d     = word_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            byte_cnt_q <= '0;
            word_q     <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            word_q     <= word_d;
        end
    end

endmodule

// File: rtl/uart_boot_ctrl.sv
// UART boot loader: parses a word-count header, writes payload words to
// instruction memory and holds the core in reset. Optional: UART_BOOT_CHECKSUM_EN.
module uart_boot_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned AddrWidth     = 12,
    parameter int unsigned BaseAddr      = 0,
    parameter int unsigned MaxWords      = 4096,
    parameter int unsigned TimeoutCycles = 1_000_000
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic                 rx_dv_i,
    input  logic [7:0]           rx_data_i,
    output logic                 mem_we_o,
    output logic [AddrWidth-1:0] mem_addr_o,
    output logic [31:0]          mem_wdata_o,
    output logic                 busy_o,
    output logic                 done_o,
    output logic                 err_o,
    output logic                 cpu_rst_o
);

    localparam int unsigned LenW = $clog2(MaxWords + 1);
    localparam int unsigned TmoW = $clog2(TimeoutCycles + 1);
`ifdef UART_BOOT_CHECKSUM_EN
    localparam boot_state_e LastState = RecvChk;
`else
    localparam boot_state_e LastState = Done;
`endif

    boot_state_e          state_q, state_d;
    logic [LenW-1:0]      len_q, len_d;
    logic [LenW-1:0]      wcnt_q, wcnt_d;
    logic [TmoW-1:0]      tmo_q, tmo_d;
    logic                 we_q, we_d;
    logic [AddrWidth-1:0] addr_q, addr_d;
    logic [31:0]          wdata_q, wdata_d;
`ifdef UART_BOOT_CHECKSUM_EN
    logic [7:0]           xor_q, xor_d;
`endif

    logic        busy;
    logic        pk_clear, pk_vld, pk_complete;
    logic [31:0] pk_word;

    assign busy   = is_busy(state_q);
    assign pk_vld = rx_dv_i && ((state_q == RecvLen) || (state_q == RecvData));

    uart_word_packer u_packer (
        .clk_i           (clk_i),
        .rst_ni          (rst_ni),
        .clear_i         (pk_clear),
        .byte_vld_i      (pk_vld),
        .byte_i          (rx_data_i),
        .word_o          (pk_word),
        .word_complete_o (pk_complete)
    );

    always_comb begin
        state_d  = state_q;
        len_d    = len_q;
        wcnt_d   = wcnt_q;
        we_d     = 1'b0;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        pk_clear = 1'b0;
        tmo_d    = (busy && !rx_dv_i) ? tmo_q + 1'b1 : '0;
`ifdef UART_BOOT_CHECKSUM_EN
        xor_d    = xor_q;
`endif
        case (state_q)
            Idle, Done, Error: begin
                if (start_i) begin
                    state_d  = RecvLen;
                    pk_clear = 1'b1;
                    wcnt_d   = '0;
                    tmo_d    = '0;
`ifdef UART_BOOT_CHECKSUM_EN
                    xor_d    = '0;
`endif
                end
            end
            RecvLen: begin
                if (pk_complete) begin
                    len_d = pk_word[LenW-1:0];
                    if (pk_word == '0)                   state_d = LastState;
                    else if (pk_word > 32'(MaxWords))    state_d = Error;
                    else                                 state_d = RecvData;
                end
            end
            RecvData: begin
`ifdef UART_BOOT_CHECKSUM_EN
                if (rx_dv_i) xor_d = xor_q ^ rx_data_i;
`endif
                // Strobe is registered, so Done arrives together with the last write.
                if (pk_complete) begin
                    we_d    = 1'b1;
                    addr_d  = AddrWidth'(BaseAddr + 32'(wcnt_q));
                    wdata_d = pk_word;
                    wcnt_d  = wcnt_q + 1'b1;
                    if (wcnt_d == len_q) state_d = LastState;
                end
            end
`ifdef UART_BOOT_CHECKSUM_EN
            RecvChk: begin
                if (rx_dv_i) state_d = (rx_data_i == xor_q) ? Done : Error;
            end
`endif
            default: state_d = Idle;
        endcase
        if (busy && !rx_dv_i && (tmo_q == TmoW'(TimeoutCycles - 1))) state_d = Error;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= Idle;
            len_q   <= '0;
            wcnt_q  <= '0;
            tmo_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef UART_BOOT_CHECKSUM_EN
            xor_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            wcnt_q  <= wcnt_d;
            tmo_q   <= tmo_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef UART_BOOT_CHECKSUM_EN
            xor_q   <= xor_d;
`endif
        end
    end

    assign mem_we_o    = we_q;
    assign mem_addr_o  = addr_q;
    assign mem_wdata_o = wdata_q;
    assign busy_o      = busy;
    assign done_o      = (state_q == Done);
    assign err_o       = (state_q == Error);
    assign cpu_rst_o   = (state_q != Done);

endmodule

// File: tb/tb_uart_boot_ctrl.sv
// Directed bench for uart_boot_ctrl: table of per-cycle vectors plus
// hand-written sequences for header limits, timeout and mid-load reset.
module tb_uart_boot_ctrl;

    localparam int unsigned TMO = 32;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        dv = 1'b0;
    logic [7:0]  data = 8'h00;
    logic        we;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic        busy, done, err, crst;

    int unsigned passed = 0;
    int unsigned total  = 0;
    int unsigned we_cnt = 0;

    uart_boot_ctrl #(
        .AddrWidth     (12),
        .BaseAddr      (0),
        .MaxWords      (4096),
        .TimeoutCycles (TMO)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .start_i     (start),
        .rx_dv_i     (dv),
        .rx_data_i   (data),
        .mem_we_o    (we),
        .mem_addr_o  (addr),
        .mem_wdata_o (wdata),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .cpu_rst_o   (crst)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (we === 1'b1) we_cnt++;

    typedef struct {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic        we;
        logic [11:0] a;
        logic [31:0] w;
        logic        b, dn, e, r;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic s, input logic v, input logic [7:0] d,
                       input logic e_we, input logic [11:0] e_a, input logic [31:0] e_w,
                       input logic e_b, input logic e_d, input logic e_e, input logic e_r);
        vec_t x;
        x.s = s; x.v = v; x.d = d; x.we = e_we; x.a = e_a; x.w = e_w;
        x.b = e_b; x.dn = e_d; x.e = e_e; x.r = e_r;
        tbl.push_back(x);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        else passed++;
    endtask

    task automatic cyc(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start = s; dv = v; data = d;
        @(posedge clk);
        #1;
    endtask

    task automatic flags(input string tag, input logic e_b, input logic e_d,
                         input logic e_e, input logic e_r);
        chk({tag, ".busy"},    32'(busy), 32'(e_b));
        chk({tag, ".done"},    32'(done), 32'(e_d));
        chk({tag, ".err"},     32'(err),  32'(e_e));
        chk({tag, ".cpu_rst"}, 32'(crst), 32'(e_r));
    endtask

    task automatic outs(input string tag, input logic e_we, input logic [11:0] e_a,
                        input logic [31:0] e_w, input logic e_b, input logic e_d,
                        input logic e_e, input logic e_r);
        chk({tag, ".we"},    32'(we),    32'(e_we));
        chk({tag, ".addr"},  32'(addr),  32'(e_a));
        chk({tag, ".wdata"}, wdata,      e_w);
        flags(tag, e_b, e_d, e_e, e_r);
    endtask

    task automatic send_hdr(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
        cyc(1'b1, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, b0);
        cyc(1'b0, 1'b1, b1);
        cyc(1'b0, 1'b1, b2);
        cyc(1'b0, 1'b1, b3);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: got time-limit expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        outs("reset", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 8'h5A);
        outs("idle_dv", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);

        // Two-word image, ignored byte in Done, restart, zero-length header.
        add(1, 0, 8'h00, 0, 12'h0, 32'h0, 1, 0, 0, 1);
        add(0, 1, 8'h02, 0, 12'h0, 32'h0, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h0, 32'h0, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h0, 32'h0, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h0, 32'h0, 1, 0, 0, 1);
        add(0, 1, 8'h11, 0, 12'h0, 32'h0, 1, 0, 0, 1);
        add(0, 1, 8'h22, 0, 12'h0, 32'h0, 1, 0, 0, 1);
        add(0, 1, 8'h33, 0, 12'h0, 32'h0, 1, 0, 0, 1);
        add(0, 1, 8'h44, 1, 12'h0, 32'h44332211, 1, 0, 0, 1);
        add(0, 0, 8'h00, 0, 12'h0, 32'h44332211, 1, 0, 0, 1);
        add(0, 1, 8'hAA, 0, 12'h0, 32'h44332211, 1, 0, 0, 1);
        add(0, 1, 8'hBB, 0, 12'h0, 32'h44332211, 1, 0, 0, 1);
        add(0, 1, 8'hCC, 0, 12'h0, 32'h44332211, 1, 0, 0, 1);
`ifdef UART_BOOT_CHECKSUM_EN
        add(0, 1, 8'hDD, 1, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h44, 0, 12'h1, 32'hDDCCBBAA, 0, 1, 0, 0);
`else
        add(0, 1, 8'hDD, 1, 12'h1, 32'hDDCCBBAA, 0, 1, 0, 0);
`endif
        add(0, 1, 8'h55, 0, 12'h1, 32'hDDCCBBAA, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
`ifdef UART_BOOT_CHECKSUM_EN
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 0, 1, 0, 0);
        add(1, 0, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 1, 0, 0, 1);
        add(0, 1, 8'h01, 0, 12'h1, 32'hDDCCBBAA, 0, 0, 1, 1);
`else
        add(0, 1, 8'h00, 0, 12'h1, 32'hDDCCBBAA, 0, 1, 0, 0);
`endif
        for (int i = 0; i < tbl.size(); i++) begin
            cyc(tbl[i].s, tbl[i].v, tbl[i].d);
            outs($sformatf("vec%0d", i), tbl[i].we, tbl[i].a, tbl[i].w,
                 tbl[i].b, tbl[i].dn, tbl[i].e, tbl[i].r);
        end
        cyc(1'b0, 1'b0, 8'h00);
        chk("strobes_table", we_cnt, 2);

        // len = MaxWords+1 is rejected right after the header.
        send_hdr(8'h01, 8'h10, 8'h00, 8'h00);
        flags("len_over", 1'b0, 1'b0, 1'b1, 1'b1);
        // len = MaxWords is accepted; stalling then times out.
        send_hdr(8'h00, 8'h10, 8'h00, 8'h00);
        flags("len_max", 1'b1, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < TMO; i++) cyc(1'b0, 1'b0, 8'h00);
        flags("len_max_tmo", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("strobes_len", we_cnt, 2);

        // Timeout after the 2nd payload byte: still busy at TMO-1 idle cycles, Error at TMO.
        send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 8'h11);
        cyc(1'b0, 1'b1, 8'h22);
        for (int i = 0; i < TMO - 1; i++) cyc(1'b0, 1'b0, 8'h00);
        flags("tmo_edge", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b0, 8'h00);
        flags("tmo_hit", 1'b0, 1'b0, 1'b1, 1'b1);
        chk("strobes_tmo", we_cnt, 2);
        send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 8'h0A);
        cyc(1'b0, 1'b1, 8'h0B);
        cyc(1'b0, 1'b1, 8'h0C);
        cyc(1'b0, 1'b1, 8'h0D);
        chk("reload.we",    32'(we),   32'd1);
        chk("reload.addr",  32'(addr), 32'd0);
        chk("reload.wdata", wdata,     32'h0D0C0B0A);
`ifdef UART_BOOT_CHECKSUM_EN
        cyc(1'b0, 1'b1, 8'h00);
`endif
        flags("reload", 1'b0, 1'b1, 1'b0, 1'b0);

        // Asynchronous reset after 3 of 4 bytes of a word.
        send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 8'h31);
        cyc(1'b0, 1'b1, 8'h32);
        cyc(1'b0, 1'b1, 8'h33);
        #2;
        rst_n = 1'b0; dv = 1'b0; start = 1'b0;
        #1;
        outs("rst_async", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(1'b0, 1'b1, 8'h34);
        cyc(1'b0, 1'b1, 8'h35);
        cyc(1'b0, 1'b0, 8'h00);
        outs("post_rst", 1'b0, 12'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("strobes_rst", we_cnt, 3);

        // start during RecvData is ignored; a byte on the timeout terminal count wins.
        send_hdr(8'h01, 8'h00, 8'h00, 8'h00);
        cyc(1'b0, 1'b1, 8'h21);
        cyc(1'b1, 1'b0, 8'h00);
        flags("start_busy", 1'b1, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 1'b1, 8'h22);
        cyc(1'b0, 1'b1, 8'h23);
        for (int i = 0; i < TMO - 1; i++) cyc(1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 8'h24);
        chk("race.we",    32'(we),   32'd1);
        chk("race.addr",  32'(addr), 32'd0);
        chk("race.wdata", wdata,     32'h24232221);
`ifdef UART_BOOT_CHECKSUM_EN
        cyc(1'b0, 1'b1, 8'h04);
`endif
        flags("race", 1'b0, 1'b1, 1'b0, 1'b0);
        cyc(1'b0, 1'b0, 8'h00);
        chk("strobes_race", we_cnt, 4);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
